// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared types and constants for the UART command controller.
package uart_cmd_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RX_CMD,
        S_RX_ADDR,
        S_RX_DATA,
        S_RX_CHK,
        S_EXEC,
        S_TX_LOAD,
        S_TX_WAIT_BUSY,
        S_TX_WAIT_DONE
    } state_t;

    localparam logic [7:0] SOF         = 8'hA5;
    localparam logic [7:0] ACK         = 8'h5A;
    localparam logic [7:0] NAK         = 8'hEE;
    localparam logic [7:0] CMD_WRITE   = 8'h01;
    localparam logic [7:0] CMD_READ    = 8'h02;

    localparam logic [7:0] NAK_CHK     = 8'h01;
    localparam logic [7:0] NAK_ADDR    = 8'h02;
    localparam logic [7:0] NAK_TIMEOUT = 8'h03;
    localparam logic [7:0] NAK_RXERR   = 8'h04;
    localparam logic [7:0] NAK_CMD     = 8'h05;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Byte-level handshake between the command controller and the uart_rx/uart_tx pair.
interface uart_cmd_if;
    logic [7:0] rx_byte;
    logic       rx_done;
    logic       rx_error;
    logic       tx_busy;
    logic       tx_done;
    logic       rx_enable;
    logic       tx_enable;
    logic       tx_write;
    logic [7:0] tx_byte;
    logic       uart_cts;

    modport master (
        input  rx_byte, rx_done, rx_error, tx_busy, tx_done,
        output rx_enable, tx_enable, tx_write, tx_byte, uart_cts
    );

    modport slave (
        output rx_byte, rx_done, rx_error, tx_busy, tx_done,
        input  rx_enable, tx_enable, tx_write, tx_byte, uart_cts
    );
endinterface

// File: rtl/uart_cmd_ctrl_sync.sv
// Multi-stage level synchronizer with a one-cycle rising-edge pulse on the synced level.
module level_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q_level,
    output logic q_rise
);
    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= q_level;
        end
    end

    assign q_level = r_sync[STAGES-1];
    assign q_rise  = q_level & ~r_prev;
endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frames 5-byte command packets from uart_rx, executes register READ/WRITE,
// and returns a 3-byte ACK/NAK response through the uart_tx write handshake.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk50,
    input  logic                  reset,
    uart_cmd_if.master            bus,
    output logic [NUM_REGS*8-1:0] reg_q,
    output logic                  cmd_busy,
    output logic [7:0]            err_count
);
    localparam int unsigned AW = $clog2(NUM_REGS);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [8:0]  NREG9 = 9'(NUM_REGS);

    logic w_rx_ev, w_rx_err, w_txb_ev, w_txd_ev;
    logic w_unused_rx_lvl, w_unused_err_rise, w_unused_txb_lvl, w_unused_txd_lvl;

    level_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_rxd (
        .clk(clk50), .reset(reset), .d(bus.rx_done),
        .q_level(w_unused_rx_lvl), .q_rise(w_rx_ev));
    level_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_rxe (
        .clk(clk50), .reset(reset), .d(bus.rx_error),
        .q_level(w_rx_err), .q_rise(w_unused_err_rise));
    level_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_txb (
        .clk(clk50), .reset(reset), .d(bus.tx_busy),
        .q_level(w_unused_txb_lvl), .q_rise(w_txb_ev));
    level_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_txd (
        .clk(clk50), .reset(reset), .d(bus.tx_done),
        .q_level(w_unused_txd_lvl), .q_rise(w_txd_ev));

    state_t          r_state, w_next;
    logic [7:0]      r_cmd, r_addr, r_data, r_chk;
    logic [7:0]      r_resp [3];
    logic [1:0]      r_idx;
    logic [TW-1:0]   r_timer;
    logic [7:0]      r_regs [NUM_REGS];
    logic [7:0]      r_err;
    logic            r_tx_write;
    logic [7:0]      r_tx_byte;

    logic            w_in_pkt, w_timeout;
    logic            w_build, w_is_nak, w_do_write;
    logic [7:0]      w_code, w_ack_val, w_b0, w_b1;
    logic [AW-1:0]   w_widx;

    assign w_in_pkt  = (r_state == S_RX_CMD) || (r_state == S_RX_ADDR) ||
                       (r_state == S_RX_DATA) || (r_state == S_RX_CHK);
    assign w_timeout = w_in_pkt && !w_rx_ev && (r_timer == TW'(TIMEOUT_CYC - 1));
    assign w_widx    = r_addr[AW-1:0];

    always_ff @(posedge clk50) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_build    = 1'b0;
        w_is_nak   = 1'b0;
        w_do_write = 1'b0;
        w_code     = '0;
        w_ack_val  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_rx_ev && !w_rx_err && bus.rx_byte == SOF) w_next = S_RX_CMD;
            end
            S_RX_CMD, S_RX_ADDR, S_RX_DATA, S_RX_CHK: begin
                if (w_rx_ev && w_rx_err) begin
                    w_build  = 1'b1;
                    w_is_nak = 1'b1;
                    w_code   = NAK_RXERR;
                    w_next   = S_TX_LOAD;
                end else if (w_rx_ev) begin
                    case (r_state)
                        S_RX_CMD:  w_next = S_RX_ADDR;
                        S_RX_ADDR: w_next = S_RX_DATA;
                        S_RX_DATA: w_next = S_RX_CHK;
                        default:   w_next = S_EXEC;
                    endcase
                end else if (w_timeout) begin
                    w_build  = 1'b1;
                    w_is_nak = 1'b1;
                    w_code   = NAK_TIMEOUT;
                    w_next   = S_TX_LOAD;
                end
            end
            S_EXEC: begin
                w_build = 1'b1;
                w_next  = S_TX_LOAD;
                if (r_chk != (r_cmd ^ r_addr ^ r_data)) begin
                    w_is_nak = 1'b1;
                    w_code   = NAK_CHK;
                end else if ({1'b0, r_addr} >= NREG9) begin
                    w_is_nak = 1'b1;
                    w_code   = NAK_ADDR;
                end else if (r_cmd == CMD_WRITE) begin
                    w_do_write = 1'b1;
                    w_ack_val  = r_data;
                end else if (r_cmd == CMD_READ) begin
                    w_ack_val  = r_regs[w_widx];
                end else begin
                    w_is_nak = 1'b1;
                    w_code   = NAK_CMD;
                end
            end
            S_TX_LOAD:      w_next = S_TX_WAIT_BUSY;
            S_TX_WAIT_BUSY: if (w_txb_ev) w_next = S_TX_WAIT_DONE;
            S_TX_WAIT_DONE: if (w_txd_ev) w_next = (r_idx == 2'd2) ? S_IDLE : S_TX_LOAD;
            default:        w_next = S_IDLE;
        endcase
    end

    assign w_b0 = w_is_nak ? NAK : ACK;
    assign w_b1 = w_is_nak ? w_code : w_ack_val;

    always_ff @(posedge clk50) begin
        if (!reset) begin
            r_cmd      <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_chk      <= '0;
            r_resp     <= '{default: '0};
            r_idx      <= '0;
            r_timer    <= '0;
            r_regs     <= '{default: '0};
            r_err      <= '0;
            r_tx_write <= 1'b0;
            r_tx_byte  <= '0;
        end else begin
            // timer only runs between bytes of a packet in progress
            if (w_rx_ev || !w_in_pkt) r_timer <= '0;
            else                      r_timer <= r_timer + TW'(1);

            if (w_rx_ev) begin
                case (r_state)
                    S_RX_CMD:  r_cmd  <= bus.rx_byte;
                    S_RX_ADDR: r_addr <= bus.rx_byte;
                    S_RX_DATA: r_data <= bus.rx_byte;
                    S_RX_CHK:  r_chk  <= bus.rx_byte;
                    default: ;
                endcase
            end

            if (w_build) begin
                r_resp[0] <= w_b0;
                r_resp[1] <= w_b1;
                r_resp[2] <= w_b0 ^ w_b1;
                r_idx     <= '0;
                if (w_is_nak) r_err <= sat_inc(r_err);
            end

            if (w_do_write) r_regs[w_widx] <= r_data;

            if (r_state == S_TX_LOAD) begin
                r_tx_byte  <= r_resp[r_idx];
                r_tx_write <= 1'b1;
            end
            if (r_state == S_TX_WAIT_BUSY && w_txb_ev) r_tx_write <= 1'b0;
            if (r_state == S_TX_WAIT_DONE && w_txd_ev && r_idx != 2'd2) r_idx <= r_idx + 2'd1;
        end
    end

    always_comb begin
        reg_q = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            reg_q[8*i +: 8] = r_regs[i];
        end
    end

    assign bus.rx_enable = 1'b1;
    assign bus.tx_enable = 1'b1;
    assign bus.tx_write  = r_tx_write;
    assign bus.tx_byte   = r_tx_byte;
    assign bus.uart_cts  = (r_state == S_IDLE) || w_in_pkt;
    assign cmd_busy      = (r_state != S_IDLE);
    assign err_count     = r_err;
endmodule
